// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS main controller.
// Build option MAIN_CTRL_ADDI_EN adds addi support (opcode 0x08).
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_RTYPEEX  = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BEQEX    = 4'd8,
    S_JEX      = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11
  } ctrl_state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Opcodes DECODE can dispatch; anything else raises illegal_op.
  function automatic logic op_supported(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
         (op == OP_BEQ)   || (op == OP_J);
`ifdef MAIN_CTRL_ADDI_EN
    ok = ok || (op == OP_ADDI);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/main_ctrl_fsm_decode.sv
// Combinational state -> datapath control decode for main_ctrl_fsm.
// ADDIEX/ADDIWB decode only exists when MAIN_CTRL_ADDI_EN is defined.
module main_ctrl_decode
  import mips_pkg::*;
(
  input  logic [3:0] i_state,
  input  logic       i_mem_ready,
  output logic       o_iord,
  output logic       o_memwrite,
  output logic       o_irwrite,
  output logic       o_regdst,
  output logic       o_memtoreg,
  output logic       o_regwrite,
  output logic       o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_aluop,
  output logic [1:0] o_pcsrc,
  output logic       o_pcwrite,
  output logic       o_branch
);

  // Undefined encodings fall through with every control at 0.
  always_comb begin
    o_iord     = 1'b0;
    o_memwrite = 1'b0;
    o_irwrite  = 1'b0;
    o_regdst   = 1'b0;
    o_memtoreg = 1'b0;
    o_regwrite = 1'b0;
    o_alusrca  = 1'b0;
    o_alusrcb  = SRCB_B;
    o_aluop    = ALUOP_ADD;
    o_pcsrc    = PCSRC_ALU;
    o_pcwrite  = 1'b0;
    o_branch   = 1'b0;
    case (i_state)
      S_FETCH: begin
        o_alusrcb = SRCB_FOUR;
        o_irwrite = i_mem_ready;
        o_pcwrite = i_mem_ready;
      end
      S_DECODE: begin
        o_alusrcb = SRCB_IMM_SH;
      end
      S_MEMADR: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        o_iord = 1'b1;
      end
      S_MEMWB: begin
        o_memtoreg = 1'b1;
        o_regwrite = 1'b1;
      end
      S_MEMWR: begin
        o_iord     = 1'b1;
        o_memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWB: begin
        o_regdst   = 1'b1;
        o_regwrite = 1'b1;
      end
      S_BEQEX: begin
        o_alusrca = 1'b1;
        o_aluop   = ALUOP_SUB;
        o_pcsrc   = PCSRC_ALUOUT;
        o_branch  = 1'b1;
      end
      S_JEX: begin
        o_pcsrc   = PCSRC_JUMP;
        o_pcwrite = 1'b1;
      end
`ifdef MAIN_CTRL_ADDI_EN
      S_ADDIEX: begin
        o_alusrca = 1'b1;
        o_alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        o_regwrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle MIPS main control FSM: state register, opcode dispatch, pc_en.
// Define MAIN_CTRL_ADDI_EN to add the addi path (ADDIEX -> ADDIWB).
module main_ctrl_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  ctrl_state_t r_state;

  logic w_memwrite;
  logic w_irwrite;
  logic w_regwrite;
  logic w_pcwrite;
  logic w_branch;
  logic w_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:   if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_RTYPEEX;
            OP_BEQ:       r_state <= S_BEQEX;
            OP_J:         r_state <= S_JEX;
`ifdef MAIN_CTRL_ADDI_EN
            OP_ADDI:      r_state <= S_ADDIEX;
`endif
            default:      r_state <= S_FETCH;
          endcase
        end
        // Only lw and sw reach MEMADR; sw is the one that needs a store.
        S_MEMADR:  r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:   if (mem_ready) r_state <= S_MEMWB;
        S_MEMWB:   r_state <= S_FETCH;
        S_MEMWR:   if (mem_ready) r_state <= S_FETCH;
        S_RTYPEEX: r_state <= S_RTYPEWB;
        S_RTYPEWB: r_state <= S_FETCH;
        S_BEQEX:   r_state <= S_FETCH;
        S_JEX:     r_state <= S_FETCH;
`ifdef MAIN_CTRL_ADDI_EN
        S_ADDIEX:  r_state <= S_ADDIWB;
        S_ADDIWB:  r_state <= S_FETCH;
`endif
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  main_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_mem_ready (mem_ready),
    .o_iord      (IorD),
    .o_memwrite  (w_memwrite),
    .o_irwrite   (w_irwrite),
    .o_regdst    (RegDst),
    .o_memtoreg  (MemtoReg),
    .o_regwrite  (w_regwrite),
    .o_alusrca   (ALUSrcA),
    .o_alusrcb   (ALUSrcB),
    .o_aluop     (ALUOp),
    .o_pcsrc     (PCSrc),
    .o_pcwrite   (w_pcwrite),
    .o_branch    (w_branch)
  );

  assign w_illegal = (r_state == S_DECODE) && !op_supported(opcode);

  // Strobes are masked by rst_n so nothing can fire while reset is held,
  // even though FETCH's IRWrite/PCWrite otherwise follow mem_ready.
  assign MemWrite   = w_memwrite & rst_n;
  assign IRWrite    = w_irwrite  & rst_n;
  assign RegWrite   = w_regwrite & rst_n;
  assign pc_en      = (w_pcwrite | (w_branch & zero)) & rst_n;
  assign illegal_op = w_illegal & rst_n;
  assign state_o    = r_state;

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Self-checking bench for main_ctrl_fsm: directed table, random programs, reset cases.
module tb_main_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       pc_en, illegal_op;
  logic [3:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MAIN_CTRL_ADDI_EN
  localparam bit ADDI_EN = 1'b1;
`else
  localparam bit ADDI_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  main_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .IorD       (IorD),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSrc      (PCSrc),
    .pc_en      (pc_en),
    .illegal_op (illegal_op),
    .state_o    (state_o)
  );

  typedef struct packed {
    logic       iord, mw, irw, regdst, m2r, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       pc_en, ill;
  } ctl_t;

  ctl_t act;
  assign act = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUOp, PCSrc, pc_en, illegal_op};

  // Instruction phases as the bench sees them.
  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3,
                 P_MEMWB = 4, P_MEMWR = 5, P_REX = 6, P_RWB = 7,
                 P_BEQ = 8, P_JEX = 9, P_AEX = 10, P_AWB = 11;

  function automatic logic supported(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) ||
           (op == 6'h02) || (ADDI_EN && op == 6'h08);
  endfunction

  // Phases after DECODE for a given opcode; -1 marks the end.
  function automatic int route_ph(input logic [5:0] op, input int idx);
    int r;
    r = -1;
    case (op)
      6'h23: r = (idx == 0) ? P_MEMADR : (idx == 1) ? P_MEMRD : (idx == 2) ? P_MEMWB : -1;
      6'h2B: r = (idx == 0) ? P_MEMADR : (idx == 1) ? P_MEMWR : -1;
      6'h00: r = (idx == 0) ? P_REX : (idx == 1) ? P_RWB : -1;
      6'h04: r = (idx == 0) ? P_BEQ : -1;
      6'h02: r = (idx == 0) ? P_JEX : -1;
      6'h08: if (ADDI_EN) r = (idx == 0) ? P_AEX : (idx == 1) ? P_AWB : -1;
      default: r = -1;
    endcase
    return r;
  endfunction

  // Zero-wait instruction lengths as stated for the core.
  function automatic int base_cycles(input logic [5:0] op);
    case (op)
      6'h23:        return 5;
      6'h2B, 6'h00: return 4;
      6'h04, 6'h02: return 3;
      6'h08:        return ADDI_EN ? 4 : 2;
      default:      return 2;
    endcase
  endfunction

  function automatic ctl_t exp_ctrl(input int ph, input logic mr, input logic z, input logic ill);
    ctl_t c;
    c = '0;
    case (ph)
      P_FETCH:  begin c.srcb = 2'b01; c.irw = mr; c.pc_en = mr; end
      P_DECODE: begin c.srcb = 2'b11; c.ill = ill; end
      P_MEMADR: begin c.srca = 1'b1; c.srcb = 2'b10; end
      P_MEMRD:  c.iord = 1'b1;
      P_MEMWB:  begin c.m2r = 1'b1; c.rw = 1'b1; end
      P_MEMWR:  begin c.iord = 1'b1; c.mw = 1'b1; end
      P_REX:    begin c.srca = 1'b1; c.aluop = 2'b10; end
      P_RWB:    begin c.regdst = 1'b1; c.rw = 1'b1; end
      P_BEQ:    begin c.srca = 1'b1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pc_en = z; end
      P_JEX:    begin c.pcsrc = 2'b10; c.pc_en = 1'b1; end
      P_AEX:    begin c.srca = 1'b1; c.srcb = 2'b10; end
      P_AWB:    c.rw = 1'b1;
      default:  ;
    endcase
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, a, e);
    end
  endtask

  // Drives one instruction from FETCH; fw wait cycles in FETCH, mw in MEMRD/MEMWR.
  task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw,
                           output int dut_len, output int mw_cnt);
    dut_len = 0;
    mw_cnt  = 0;
    for (int w = 0; w <= fw; w++) begin
      @(negedge clk);
      mem_ready = (w == fw);
      opcode    = 6'($urandom);
      zero      = 1'($urandom);
      #1;
      check("fetch_ctl", act, exp_ctrl(P_FETCH, mem_ready, zero, 1'b0));
      check("fetch_state", state_o, 0);
      if (state_o == 4'd0) dut_len++;
    end
    @(negedge clk);
    mem_ready = 1'($urandom);
    opcode    = op;
    zero      = 1'($urandom);
    #1;
    check("decode_ctl", act, exp_ctrl(P_DECODE, mem_ready, zero, !supported(op)));
    check("decode_state", state_o != 4'd0, 1);
    if (state_o != 4'd0) dut_len++;
    for (int i = 0; route_ph(op, i) >= 0; i++) begin
      int ph;
      int waits;
      ph    = route_ph(op, i);
      waits = (ph == P_MEMRD || ph == P_MEMWR) ? mw : 0;
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        mem_ready = (ph == P_MEMRD || ph == P_MEMWR) ? (w == waits) : 1'($urandom);
        opcode    = (ph == P_MEMADR) ? op : 6'($urandom);
        zero      = (ph == P_BEQ) ? z : 1'($urandom);
        #1;
        check("phase_ctl", act, exp_ctrl(ph, mem_ready, zero, 1'b0));
        check("phase_state", state_o != 4'd0, 1);
        if (state_o != 4'd0) dut_len++;
        if (MemWrite && IorD) mw_cnt++;
      end
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         fw;
    int         mw;
    int         cycles;
    int         mw_len;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int len;
    int mwc;
    logic [5:0] pool[8];

    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    zero      = 1'b1;

    // Reset hold with mem_ready high: no strobes, FETCH selects.
    repeat (2) @(negedge clk);
    #1;
    check("rst_irwrite", IRWrite, 0);
    check("rst_pc_en", pc_en, 0);
    check("rst_state", state_o, 0);
    check("rst_ctl", act, exp_ctrl(P_FETCH, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    #1;
    check("post_rst_irwrite", IRWrite, 1);
    check("post_rst_pc_en", pc_en, 1);
    #1 mem_ready = 1'b0;

    vecs[0] = '{6'h23, 1'b0, 0, 0, 5, 0};
    vecs[1] = '{6'h2B, 1'b0, 0, 3, 7, 4};
    vecs[2] = '{6'h04, 1'b1, 0, 0, 3, 0};
    vecs[3] = '{6'h04, 1'b0, 0, 0, 3, 0};
    vecs[4] = '{6'h00, 1'b0, 0, 0, 4, 0};
    vecs[5] = '{6'h02, 1'b0, 0, 0, 3, 0};
    vecs[6] = '{6'h3F, 1'b0, 0, 0, 2, 0};
    vecs[7] = '{6'h08, 1'b0, 0, 0, ADDI_EN ? 4 : 2, 0};
    vecs[8] = '{6'h23, 1'b1, 2, 1, 8, 0};
    vecs[9] = '{6'h2B, 1'b1, 0, 0, 4, 1};

    for (int i = 0; i < 10; i++) begin
      run_instr(vecs[i].op, vecs[i].z, vecs[i].fw, vecs[i].mw, len, mwc);
      check($sformatf("vec%0d_len", i), len, vecs[i].cycles);
      check($sformatf("vec%0d_memwrite_len", i), mwc, vecs[i].mw_len);
    end

    pool[0] = 6'h00; pool[1] = 6'h23; pool[2] = 6'h2B; pool[3] = 6'h04;
    pool[4] = 6'h02; pool[5] = 6'h08; pool[6] = 6'h3F; pool[7] = 6'h00;
    for (int i = 0; i < 150; i++) begin
      logic [5:0] op;
      int fw;
      int mw;
      int exp_len;
      op = (i % 9 == 8) ? 6'($urandom) : pool[$urandom_range(0, 7)];
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 2);
      exp_len = base_cycles(op) + fw + ((op == 6'h23 || op == 6'h2B) ? mw : 0);
      run_instr(op, 1'($urandom), fw, mw, len, mwc);
      check("rand_len", len, exp_len);
      check("rand_memwrite_len", mwc, (op == 6'h2B) ? mw + 1 : 0);
    end

    // Asynchronous reset in the middle of a stalled store.
    @(negedge clk);
    mem_ready = 1'b1;
    opcode    = 6'h2B;
    repeat (3) @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("sw_before_abort", MemWrite, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_memwrite", MemWrite, 0);
    check("abort_state", state_o, 0);
    check("abort_ctl", act, exp_ctrl(P_FETCH, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check("abort_hold_irwrite", IRWrite, 0);
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("abort_release_state", state_o, 0);
    run_instr(6'h23, 1'b0, 0, 0, len, mwc);
    check("after_abort_len", len, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
